// File: rtl/serial_subtractor_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_subtractor_pkg;
   localparam int DEFAULT_N = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;
endpackage

// File: rtl/serial_subtractor_if.sv
// Request/result bundle between a requester (master) and the subtractor (slave).
// start is sampled on each rising clk edge; A/B are captured only on the edge that accepts start.
interface serial_subtractor_if
   import serial_subtractor_pkg::*;
#(
   parameter int N = DEFAULT_N
) ();
   logic         start;
   logic [N-1:0] A;
   logic [N-1:0] B;
   logic         busy;
   logic         done;
   logic [N-1:0] D;
   logic         Bo;

   modport master (
      output start, A, B,
      input  busy, done, D, Bo
   );

   modport slave (
      input  start, A, B,
      output busy, done, D, Bo
   );
endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor: d = a - b - bin, with borrow out.
module full_subtractor (
   input  logic a,
   input  logic b,
   input  logic bin,
   output logic d,
   output logic bout
);
   assign d    = a ^ b ^ bin;
   assign bout = (~a & b) | (~(a ^ b) & bin);
endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: processes one bit pair per clock, LSB first, and
// publishes (A - B) mod 2^N plus the final borrow after N shift cycles.
module serial_subtractor
   import serial_subtractor_pkg::*;
#(
   parameter int N = DEFAULT_N
) (
   input  logic                 clk,
   input  logic                 rst,
   serial_subtractor_if.slave   sub_if,
   output state_e               state_o
);
   localparam int CW = (N > 1) ? $clog2(N) : 1;
   localparam logic [CW-1:0] LAST = CW'(N - 1);

   state_e        state_q;
   logic [CW-1:0] cnt_q;
   logic [N-1:0]  a_q, b_q, r_q, d_q;
   logic          bor_q, bo_q, busy_q, done_q;

   logic          diff_bit, bout_bit;
   logic [N-1:0]  r_d;

   full_subtractor u_fs (
      .a    (a_q[0]),
      .b    (b_q[0]),
      .bin  (bor_q),
      .d    (diff_bit),
      .bout (bout_bit)
   );

   // Difference bits enter at the MSB so after N shifts bit 0 sits at the LSB.
   assign r_d = {diff_bit, r_q[N-1:1]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         r_q     <= '0;
         d_q     <= '0;
         bor_q   <= 1'b0;
         bo_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE, DONE: begin
               if (sub_if.start) begin
                  a_q     <= sub_if.A;
                  b_q     <= sub_if.B;
                  bor_q   <= 1'b0;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
                  state_q <= SHIFT;
               end else begin
                  busy_q  <= 1'b0;
                  state_q <= IDLE;
               end
            end
            SHIFT: begin
               a_q   <= a_q >> 1;
               b_q   <= b_q >> 1;
               r_q   <= r_d;
               bor_q <= bout_bit;
               if (cnt_q == LAST) begin
                  d_q     <= r_d;
                  bo_q    <= bout_bit;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  cnt_q   <= '0;
                  state_q <= DONE;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: begin
               busy_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign sub_if.busy = busy_q;
   assign sub_if.done = done_q;
   assign sub_if.D    = d_q;
   assign sub_if.Bo   = bo_q;
   assign state_o     = state_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed and exhaustive bench for the N=4 serial subtractor.
module tb_serial_subtractor;
   import serial_subtractor_pkg::*;

   localparam int N = 4;
   localparam int W = N + 1;

   logic   clk;
   logic   rst;
   state_e dbg_state;

   int checks = 0;
   int errors = 0;
   logic [W-1:0] exp_q[$];

   serial_subtractor_if #(.N(N)) sub_if ();

   serial_subtractor #(.N(N)) dut (
      .clk     (clk),
      .rst     (rst),
      .sub_if  (sub_if.slave),
      .state_o (dbg_state)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0d exp=%0d", tag, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // driver: present an operation for exactly one edge, then scramble the operands
   task automatic accept(input logic [N-1:0] a, input logic [N-1:0] b);
      sub_if.start = 1'b1;
      sub_if.A     = a;
      sub_if.B     = b;
      tick();
      sub_if.start = 1'b0;
      sub_if.A     = N'($urandom_range(0, 15));
      sub_if.B     = N'($urandom_range(0, 15));
   endtask

   // waits for done; pops the scoreboard when it arrives
   task automatic wait_done(input string tag, output int lat, output int busy_cnt);
      logic [W-1:0] exp;
      lat      = 0;
      busy_cnt = 0;
      while (sub_if.done !== 1'b1 && lat < 20) begin
         if (sub_if.busy === 1'b1) busy_cnt++;
         tick();
         lat++;
      end
      check({tag, "_done_seen"}, 32'(sub_if.done), 32'd1);
      if (sub_if.done === 1'b1) begin
         if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 32'd1, 32'd0);
         end else begin
            exp = exp_q.pop_front();
            check({tag, "_result"}, 32'({sub_if.Bo, sub_if.D}), 32'(exp));
         end
      end
   endtask

   task automatic run_op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic [N-1:0] exp_d, input logic exp_bo, input bit full);
      int lat, bcnt;
      exp_q.push_back({exp_bo, exp_d});
      accept(a, b);
      wait_done(tag, lat, bcnt);
      if (full) begin
         check({tag, "_latency"}, 32'(lat), 32'(N));
         check({tag, "_busy_cycles"}, 32'(bcnt), 32'(N));
         check({tag, "_state_done"}, 32'(dbg_state), 32'(DONE));
      end
      tick();
      check({tag, "_done_pulse"}, 32'(sub_if.done), 32'd0);
   endtask

   initial begin
      int lat, bcnt, dones;
      rst          = 1'b1;
      sub_if.start = 1'b0;
      sub_if.A     = '0;
      sub_if.B     = '0;
      #12;
      check("rst_D", 32'(sub_if.D), 32'd0);
      check("rst_Bo", 32'(sub_if.Bo), 32'd0);
      check("rst_busy", 32'(sub_if.busy), 32'd0);
      check("rst_done", 32'(sub_if.done), 32'd0);
      check("rst_state", 32'(dbg_state), 32'(IDLE));
      tick();
      rst = 1'b0;

      // basic and boundary vectors, first one accepted on the first edge after reset
      run_op("basic_9_5", 4'd9, 4'd5, 4'd4, 1'b0, 1'b1);
      run_op("borrow_3_5", 4'd3, 4'd5, 4'd14, 1'b1, 1'b1);
      run_op("zero_0_0", 4'd0, 4'd0, 4'd0, 1'b0, 1'b1);
      run_op("max_15_15", 4'd15, 4'd15, 4'd0, 1'b0, 1'b1);
      run_op("wrap_0_15", 4'd0, 4'd15, 4'd1, 1'b1, 1'b1);
      check("idle_after", 32'(dbg_state), 32'(IDLE));

      // start while busy is ignored
      exp_q.push_back({1'b0, 4'd7});
      accept(4'd10, 4'd3);
      sub_if.start = 1'b1;
      sub_if.A     = 4'd1;
      sub_if.B     = 4'd1;
      tick();
      sub_if.start = 1'b0;
      check("busy_ign_hold_D", 32'(sub_if.D), 32'd1);
      wait_done("busy_ign", lat, bcnt);
      check("busy_ign_latency", 32'(lat), 32'(N - 1));
      dones = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         if (sub_if.done === 1'b1) dones++;
      end
      check("busy_ign_extra_done", 32'(dones), 32'd0);
      check("busy_ign_idle", 32'(dbg_state), 32'(IDLE));

      // back-to-back: start held in the DONE cycle
      exp_q.push_back({1'b0, 4'd4});
      accept(4'd9, 4'd5);
      wait_done("b2b_first", lat, bcnt);
      check("b2b_done_busy_low", 32'(sub_if.busy), 32'd0);
      exp_q.push_back({1'b0, 4'd5});
      accept(4'd7, 4'd2);
      check("b2b_busy_again", 32'(sub_if.busy), 32'd1);
      check("b2b_no_done", 32'(sub_if.done), 32'd0);
      check("b2b_hold_D", 32'(sub_if.D), 32'd4);
      wait_done("b2b_second", lat, bcnt);
      check("b2b_latency", 32'(lat), 32'(N));
      check("b2b_busy_cycles", 32'(bcnt), 32'(N));
      tick();

      // reset in the second SHIFT cycle aborts with no done
      accept(4'd9, 4'd5);
      tick();
      #2 rst = 1'b1;
      #1;
      check("mid_rst_D", 32'(sub_if.D), 32'd0);
      check("mid_rst_Bo", 32'(sub_if.Bo), 32'd0);
      check("mid_rst_busy", 32'(sub_if.busy), 32'd0);
      check("mid_rst_state", 32'(dbg_state), 32'(IDLE));
      dones = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (sub_if.done === 1'b1) dones++;
      end
      rst = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (sub_if.done === 1'b1) dones++;
      end
      check("mid_rst_no_done", 32'(dones), 32'd0);
      run_op("post_rst_12_4", 4'd12, 4'd4, 4'd8, 1'b0, 1'b1);

      // exhaustive sweep against a reference model
      for (int a = 0; a < 16; a++) begin
         for (int b = 0; b < 16; b++) begin
            logic [N-1:0] md;
            md = N'(a - b);
            run_op($sformatf("ex_%0d_%0d", a, b), N'(a), N'(b), md, (a < b), 1'b0);
         end
      end
      check("sb_drained", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter N, default 4, operand and result width in bits; legal range 2..16.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 start  input  1  request a subtraction; sampled on rising clk edge.
REQ-005 A  input  N  minuend; sampled only on the edge that accepts start.
REQ-006 B  input  N  subtrahend; sampled only on the edge that accepts start.
REQ-007 busy  output  1  high while a subtraction is in progress.
REQ-008 done  output  1  one-cycle pulse when D/Bo are updated.
REQ-009 D  output  N  difference (A - B) mod 2^N, registered.
REQ-010 Bo  output  1  final borrow out; 1 iff A < B unsigned.

Function
REQ-011 FSM states are IDLE, SHIFT and DONE, and there are no others.
REQ-012 Start is accepted in IDLE or DONE, and ignored in SHIFT.
REQ-013 Accept edge: load A and B into internal shift registers; clear the borrow flop and the bit counter; go to SHIFT.
REQ-014 Each SHIFT edge processes one bit pair, LSB first.
REQ-015 Per-bit difference = a ^ b ^ bin.
REQ-016 Per-bit borrow = (~a & b) | (~(a ^ b) & bin).
REQ-017 The difference bit enters the result shift register at the MSB end; operand registers shift right by one.
REQ-018 Counter counts 0..N-1; the edge that processes bit N-1 loads D from the result register and Bo from the final borrow, then goes to DONE.
REQ-019 Latency: start accepted at edge k; D, Bo and done are valid after edge k+N; done high exactly one cycle.
REQ-020 busy is high in SHIFT only; busy is low in IDLE and DONE.
REQ-021 DONE -> IDLE on the next edge if start is low; DONE -> SHIFT if start is high (back-to-back, no bubble).
REQ-022 D and Bo hold their last result until the next completion; they are not cleared or changed while a new operation runs.
REQ-023 Changes on A or B after the accept edge do not affect the running operation.
REQ-024 Counter wrap: the counter never exceeds N-1; no wrap-around state is reachable.

Reset
REQ-025 rst high immediately forces state to IDLE, with no clock required.
REQ-026 rst high immediately drives D=0, Bo=0, busy=0, done=0, and clears the counter, borrow and shift registers.
REQ-027 Reset during SHIFT aborts the operation; no done pulse is produced for the aborted operation.
REQ-028 After rst falls, the first start is accepted on the first rising edge where rst is low.

Structure
REQ-029 A shared package holds the state enumeration (IDLE/SHIFT/DONE) and the default width constant N=4.
REQ-030 A single combinational sub-module full_subtractor(a, b, bin, d, bout) implements REQ-015 and REQ-016 and is instantiated once.
REQ-031 All registers reside in serial_subtractor; the whole design is synchronous to clk apart from the asynchronous reset.

Verification
REQ-032 Basic subtraction: N=4, A=9, B=5, start pulse -> done exactly 4 cycles after accept, D=4, Bo=0, busy high for 4 cycles.
REQ-033 Borrow case: A=3, B=5 -> D=14, Bo=1; boundary pairs: A=0, B=0 -> D=0, Bo=0; A=15, B=15 -> D=0, Bo=0; A=0, B=15 -> D=1, Bo=1.
REQ-034 Start while busy: start=1 with A=1, B=1 during SHIFT -> ignored; result of the original operation delivered unchanged; single done pulse.
REQ-035 Back-to-back: start held high in the DONE cycle with A=7, B=2 -> second done 4 cycles later, D=5, Bo=0; busy low only in the DONE cycle.
REQ-036 Reset mid-operation: rst asserted in SHIFT cycle 2 -> outputs 0 immediately; no done pulse; next operation A=12, B=4 yields D=8, Bo=0.
REQ-037 Exhaustive self-check: all 256 A/B pairs at N=4 compared against a reference model of (A-B) mod 16 and A<B.
